// File: rtl/priority_encoder_q.sv
// Sequential N-to-log2(N) priority encoder: captures request pulses and hands them off one index per valid/ready grant.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the lowest pending index wins.
module priority_encoder_q #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [W-1:0] dout,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pend,
    output logic         err
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] dout_q;
    logic [W-1:0] dout_d;
    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;
    logic         err_q;
    logic         err_d;

    logic         hs;
    logic [N-1:0] clr;
    logic [N-1:0] cap;
    logic [N-1:0] rem;
    logic [W-1:0] search_start;

    // First set bit of x at or above start, wrapping modulo N
    function automatic logic [W-1:0] sel(input logic [N-1:0] x, input logic [W-1:0] start);
        logic [W-1:0] idx;
        logic         found;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = start + W'(k);
            if (!found && x[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign hs  = (state_q == HOLD) && ready;
    assign clr = hs ? (N'(1) << dout_q) : '0;
    assign cap = req & {N{en}};
    assign rem = pend_q & ~clr;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] rr_q;

    // Last granted line drops to lowest priority
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else if (hs) begin
            rr_q <= dout_q + W'(1);
        end
    end

    assign search_start = rr_q;
`else
    assign search_start = '0;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dout_q  <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // Next state: grant while anything is pending, drain back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (|pend_q) state_d = HOLD;
            HOLD: if (hs && !(|rem)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next output values; a same-cycle request on the cleared bit re-arms it
    always_comb begin
        dout_d = dout_q;
        pend_d = rem | cap;
        err_d  = |(cap & rem);
        case (state_q)
            IDLE: if (|pend_q) dout_d = sel(pend_q, search_start);
            HOLD: if (hs && (|rem)) dout_d = sel(rem, search_start);
            default: dout_d = dout_q;
        endcase
    end

    assign dout  = dout_q;
    assign valid = (state_q == HOLD);
    assign pend  = pend_q;
    assign err   = err_q;

endmodule
